// File: rtl/fifo_reader.sv
// ----------------------------------------------------------------------------
// fifo_reader
//
// Drains words from a synchronous FIFO into a 2-entry output queue with a
// valid/ready downstream interface. The FIFO empty flag is registered inside
// the FIFO and lags its true occupancy by one cycle. For that reason the
// reader only pops back-to-back while the FIFO reports plenty of data. Once
// the low-occupancy flag rises, it pops at most every other cycle, so the
// empty flag can catch up between pops.
//
// State table
//   state      | meaning
//   -----------+------------------------------------------------------------
//   IDLE       | no pops; waits for enable with a non-empty FIFO
//   BURST      | FIFO well stocked; pops every cycle while space allows
//   PACED_RD   | FIFO nearly empty; may issue one pop
//   PACED_GAP  | forced one-cycle pause after a paced pop (flag lag cover)
//
// Ports
//   clk                in   clock, rising-edge
//   reset              in   synchronous, active-low
//   enable             in   high allows new pops
//   fifo_empty         in   FIFO empty flag (one cycle stale)
//   fifo_almost_empty  in   FIFO low-occupancy flag
//   fifo_data          in   FIFO read data, valid the cycle after fifo_rd
//   fifo_rd            out  pop request (combinational)
//   out_data           out  head word of the output queue
//   out_valid          out  out_data holds a word
//   out_ready          in   downstream accepts out_data this cycle
//   word_count         out  downstream transfers, modulo 2^CNT_WIDTH
//   state              out  FSM state encoding (see table)
// ----------------------------------------------------------------------------
module fifo_reader #(
    parameter int DATA_WIDTH = 6,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic                  fifo_almost_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CNT_WIDTH-1:0]  word_count,
    output logic [1:0]            state
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BURST     = 2'd1,
        PACED_RD  = 2'd2,
        PACED_GAP = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    state_t                state_q;
    state_t                state_d;
    logic                  inflight;
    logic [1:0]            buf_cnt;
    logic [DATA_WIDTH-1:0] buf_mem [2];
    logic                  xfer;
    logic [2:0]            slots;
    logic                  rd_state;

    // ------------------------------------------------------------------
    // Output queue view: entry 0 is always the head.
    // ------------------------------------------------------------------
    assign out_valid = (buf_cnt != 2'd0);
    assign out_data  = buf_mem[0];
    assign xfer      = out_valid & out_ready;
    assign state     = state_q;

    // Queue space still committed after this edge: words held, plus the
    // word returning from an earlier pop, minus the word leaving now.
    // A new pop is allowed only if it still fits in the queue.
    assign slots    = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, xfer};
    assign rd_state = (state_q == BURST) || (state_q == PACED_RD);

    // fifo_rd is gated by reset so nothing is popped while the block is
    // held in reset. Otherwise that word would be lost.
    assign fifo_rd = reset & enable & ~fifo_empty & rd_state & (slots < 3'd2);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (enable && !fifo_empty) begin
                    state_d = fifo_almost_empty ? PACED_RD : BURST;
                end
            end
            BURST: begin
                if (!enable || fifo_empty) begin
                    state_d = IDLE;
                end else if (fifo_almost_empty) begin
                    state_d = PACED_RD;
                end
            end
            PACED_RD: begin
                if (!enable || fifo_empty) begin
                    state_d = IDLE;
                end else if (fifo_rd) begin
                    state_d = PACED_GAP;
                end else if (!fifo_almost_empty) begin
                    state_d = BURST;
                end
            end
            PACED_GAP: begin
                state_d = PACED_RD;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, in-flight tracking, output queue and transfer counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            inflight   <= 1'b0;
            buf_cnt    <= 2'd0;
            buf_mem[0] <= '0;
            buf_mem[1] <= '0;
            word_count <= '0;
        end else begin
            state_q  <= state_d;
            inflight <= fifo_rd;

            if (xfer) begin
                word_count <= word_count + CNT_ONE;
            end

            // When inflight is set, fifo_data carries the word popped last
            // cycle. A write with no transfer can only see buf_cnt of 0 or 1,
            // because the pop was gated on queue space.
            case ({inflight, xfer})
                2'b10: begin
                    buf_mem[buf_cnt[0]] <= fifo_data;
                    buf_cnt             <= buf_cnt + 2'd1;
                end
                2'b01: begin
                    buf_mem[0] <= buf_mem[1];
                    buf_cnt    <= buf_cnt - 2'd1;
                end
                2'b11: begin
                    // The head leaves and a new word arrives, so the count
                    // holds. The new word goes behind any remaining entry.
                    if (buf_cnt == 2'd1) begin
                        buf_mem[0] <= fifo_data;
                    end else begin
                        buf_mem[0] <= buf_mem[1];
                        buf_mem[1] <= fifo_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_reader.sv
// ----------------------------------------------------------------------------
// tb_fifo_reader
//
// Testbench for fifo_reader. A behavioural FIFO model drives the flags:
// empty lags occupancy by one cycle, and almost_empty tracks occupancy
// against a tunable threshold. Every word the FIFO hands out is queued as
// an expected output. A reset discards everything not yet delivered. A
// negedge monitor compares the DUT output stream and word_count against
// that queue.
// ----------------------------------------------------------------------------
module tb_fifo_reader;

    localparam int DW = 6;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic          fifo_empty = 1'b1;
    logic          fifo_almost_empty = 1'b1;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_rd;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] word_count;
    logic [1:0]    state;

    fifo_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk               (clk),
        .reset             (reset),
        .enable            (enable),
        .fifo_empty        (fifo_empty),
        .fifo_almost_empty (fifo_almost_empty),
        .fifo_data         (fifo_data),
        .fifo_rd           (fifo_rd),
        .out_data          (out_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .word_count        (word_count),
        .state             (state)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] fifo_q [$];
    logic [DW-1:0] pend_q [$];
    logic [DW-1:0] exp_q  [$];
    int            ae_th = 2;
    int            pops = 0;
    int            delivered = 0;
    int            exp_count = 0;
    logic          rd_seen = 1'b0;
    logic          rst_seen = 1'b0;

    task automatic check(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // FIFO model and expected-stream producer.
    int            m_old_cnt;
    logic [DW-1:0] m_word;
    always @(posedge clk) begin
        #1;
        m_old_cnt = fifo_q.size();
        if (!rst_seen) exp_q.delete();
        if (rd_seen) begin
            check(fifo_q.size() > 0, "underflow", fifo_q.size(), 1);
            if (fifo_q.size() > 0) begin
                m_word = fifo_q.pop_front();
                fifo_data = m_word;
                exp_q.push_back(m_word);
                pops++;
            end
        end else begin
            fifo_data = DW'($urandom());
        end
        while (pend_q.size() > 0) fifo_q.push_back(pend_q.pop_front());
        fifo_empty = (m_old_cnt == 0);
        fifo_almost_empty = (fifo_q.size() <= ae_th);
    end

    // Output monitor / scoreboard.
    logic [DW-1:0] s_word;
    always @(negedge clk) begin
        rd_seen  = fifo_rd;
        rst_seen = reset;
        if (!reset) check(fifo_rd == 1'b0, "rd_in_reset", fifo_rd, 0);
        if (fifo_empty) check(fifo_rd == 1'b0, "rd_while_empty", fifo_rd, 0);
        check(word_count == CW'(exp_count), "word_count", word_count, exp_count);
        if (out_valid) begin
            check(exp_q.size() > 0, "unexpected_valid", out_data, -1);
            if (exp_q.size() > 0) check(out_data == exp_q[0], "out_data", out_data, exp_q[0]);
        end
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() > 0) s_word = exp_q.pop_front();
            exp_count = (exp_count + 1) % (2 ** CW);
            delivered++;
        end
        if (!reset) exp_count = 0;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        enable = 1'b1;
        out_ready = 1'b1;
        ae_th = 2;
        while ((fifo_q.size() != 0 || pend_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
            cyc(1);
            n++;
        end
        check(n < budget, "drain_timeout", n, budget);
        enable = 1'b0;
        cyc(3);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_rd, first_v, last_v, nv, d0, found;
        int rdc [$];
        logic prev_rd;

        // Reset state
        reset = 1'b0;
        cyc(3);
        @(negedge clk);
        check(state == 2'd0, "rst_state", state, 0);
        check(out_valid == 1'b0, "rst_valid", out_valid, 0);
        check(out_data == '0, "rst_data", out_data, 0);
        check(word_count == '0, "rst_count", word_count, 0);
        cyc(1);
        reset = 1'b1;

        // Burst of 4 preloaded words
        ae_th = 2;
        for (int i = 1; i <= 4; i++) pend_q.push_back(DW'(i));
        cyc(3);
        enable = 1'b1;
        out_ready = 1'b1;
        first_rd = -1; first_v = -1; last_v = -1; nv = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (fifo_rd && first_rd < 0) first_rd = c;
            if (out_valid) begin
                if (first_v < 0) first_v = c;
                last_v = c;
                nv++;
            end
        end
        check(nv == 4, "burst_words", nv, 4);
        check(last_v - first_v == 3, "burst_consecutive", last_v - first_v, 3);
        check(first_v == first_rd + 2, "burst_latency", first_v - first_rd, 2);
        check(word_count == 8'd4, "burst_count", word_count, 4);
        cyc(1);
        enable = 1'b0;
        cyc(2);

        // Backpressure
        for (int i = 1; i <= 6; i++) pend_q.push_back(DW'(i));
        cyc(3);
        out_ready = 1'b0;
        d0 = pops;
        enable = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (out_valid) check(out_data == 6'd1, "bp_hold", out_data, 1);
        end
        check(pops - d0 <= 2, "bp_pops", pops - d0, 2);
        check(out_valid == 1'b1, "bp_valid", out_valid, 1);
        d0 = delivered;
        cyc(1);
        drain(100);
        check(delivered - d0 == 6, "bp_delivered", delivered - d0, 6);

        // Paced reads with almost_empty asserted
        ae_th = 7;
        for (int i = 10; i <= 12; i++) pend_q.push_back(DW'(i));
        cyc(3);
        ae_th = 7;
        out_ready = 1'b1;
        enable = 1'b1;
        prev_rd = 1'b0;
        rdc.delete();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (prev_rd) check(state == 2'd3 && !fifo_rd, "paced_gap", state, 3);
            if (fifo_rd) begin
                rdc.push_back(c);
                check(state == 2'd2, "paced_rd_state", state, 2);
            end
            prev_rd = fifo_rd;
        end
        check(rdc.size() == 3, "paced_pops", rdc.size(), 3);
        if (rdc.size() == 3) begin
            check(rdc[1] - rdc[0] == 2, "paced_spacing1", rdc[1] - rdc[0], 2);
            check(rdc[2] - rdc[1] == 2, "paced_spacing2", rdc[2] - rdc[1], 2);
        end
        check(state == 2'd0, "paced_end_idle", state, 0);
        cyc(1);
        drain(100);

        // Enable drop right after a pop
        for (int i = 20; i < 28; i++) pend_q.push_back(DW'(i));
        cyc(3);
        out_ready = 1'b1;
        enable = 1'b1;
        found = 0;
        for (int c = 0; c < 10 && found == 0; c++) begin
            @(negedge clk);
            if (fifo_rd) found = 1;
        end
        check(found == 1, "drop_first_rd", found, 1);
        cyc(1);
        enable = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check(fifo_rd == 1'b0, "drop_no_rd", fifo_rd, 0);
        end
        check(state == 2'd0, "drop_idle", state, 0);
        check(exp_q.size() == 0 && !out_valid, "drop_delivered", exp_q.size(), 0);
        cyc(1);
        drain(100);

        // Reset mid-burst with buffered and in-flight words
        for (int i = 30; i < 38; i++) pend_q.push_back(DW'(i));
        cyc(3);
        out_ready = 1'b0;
        enable = 1'b1;
        cyc(6);
        out_ready = 1'b1;
        @(negedge clk);
        check(out_valid && fifo_rd, "pre_reset_pop", {out_valid, fifo_rd}, 3);
        cyc(1);
        reset = 1'b0;
        out_ready = 1'b0;
        cyc(1);
        reset = 1'b1;
        enable = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check(out_valid == 1'b0, "post_reset_valid", out_valid, 0);
            check(word_count == '0, "post_reset_count", word_count, 0);
        end
        cyc(1);
        drain(100);

        // Counter wrap after 256 transfers
        reset = 1'b0;
        cyc(1);
        reset = 1'b1;
        d0 = delivered;
        for (int i = 0; i < 256; i++) pend_q.push_back(DW'(i % 64));
        cyc(1);
        drain(2000);
        check(delivered - d0 == 256, "wrap_delivered", delivered - d0, 256);
        @(negedge clk);
        check(word_count == '0, "wrap_count", word_count, 0);
        cyc(1);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) ae_th = $urandom_range(2, 5);
            enable = ($urandom_range(0, 9) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0 && fifo_q.size() < 16) pend_q.push_back(DW'($urandom()));
            reset = ($urandom_range(0, 299) != 0);
            cyc(1);
        end
        reset = 1'b1;
        drain(500);
        check(out_valid == 1'b0, "final_idle", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 Parameter: DATA_WIDTH, default 6, width of FIFO words and of the downstream data path.
REQ-002 Parameter: CNT_WIDTH, default 8, width of the delivered-word counter.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset, synchronous, active-low.
REQ-005 enable  input  1  high = reader may issue pops.
REQ-006 fifo_empty  input  1  FIFO empty flag, registered in the FIFO and lagging by one cycle.
REQ-007 fifo_almost_empty  input  1  FIFO low-occupancy flag, nonzero threshold.
REQ-008 fifo_data  input  DATA_WIDTH  FIFO read data, valid exactly 1 cycle after the cycle in which fifo_rd is high.
REQ-009 fifo_rd  output  1  pop request to the FIFO, combinational from registered state and inputs.
REQ-010 out_data  output  DATA_WIDTH  head word of the internal output buffer.
REQ-011 out_valid  output  1  out_data holds a valid word.
REQ-012 out_ready  input  1  downstream accepts; a transfer occurs when out_valid and out_ready are both high at a rising edge.
REQ-013 word_count  output  CNT_WIDTH  number of downstream transfers, wraps modulo 2^CNT_WIDTH.
REQ-014 state  output  2  current FSM state: IDLE=0, BURST=1, PACED_RD=2, PACED_GAP=3.

Function
REQ-015 Output buffer SHALL be a 2-entry in-order queue; out_data/out_valid reflect the head; out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-016 inflight SHALL be a 1-bit register set in any cycle where fifo_rd=1 and cleared otherwise; when inflight=1, fifo_data SHALL be written to the buffer tail at the next edge.
REQ-017 slots = buf_cnt + inflight - (out_valid & out_ready); fifo_rd SHALL be asserted only if slots < 2, enable=1, fifo_empty=0, and state is BURST or PACED_RD.
REQ-018 FSM, IDLE: go to BURST if enable=1, fifo_empty=0 and fifo_almost_empty=0; go to PACED_RD if enable=1, fifo_empty=0 and fifo_almost_empty=1; otherwise stay.
REQ-019 FSM, BURST: back-to-back pops allowed; go to PACED_RD on fifo_almost_empty=1; go to IDLE on enable=0 or fifo_empty=1.
REQ-020 FSM, PACED_RD: pop per REQ-017; go to PACED_GAP after a cycle in which fifo_rd=1; go to IDLE on enable=0 or fifo_empty=1; go to BURST on fifo_almost_empty=0.
REQ-021 FSM, PACED_GAP: fifo_rd=0 for exactly one cycle, then go to PACED_RD. The gap covers the one-cycle flag lag so the FIFO is never popped past empty.
REQ-022 Simultaneous buffer write (from inflight) and downstream transfer in one cycle SHALL keep buf_cnt unchanged and preserve order.
REQ-023 Deasserting enable SHALL stop new pops only; an in-flight word SHALL still be captured, and buffered words SHALL still be delivered.
REQ-024 word_count SHALL increment by 1 on each transfer and wrap from 2^CNT_WIDTH-1 to 0.
REQ-025 Sustained throughput in BURST with out_ready=1 SHALL be 1 word/cycle; first out_valid SHALL appear 2 cycles after the first fifo_rd.

Reset
REQ-026 While reset=0 at an edge, the block SHALL set state=IDLE, buf_cnt=0, inflight=0, out_valid=0, out_data=0 and word_count=0; fifo_rd SHALL be 0 during reset.
REQ-027 Reset asserted mid-operation SHALL discard buffered and in-flight words; data returned by the FIFO in the following cycle SHALL NOT be captured.

Verification
REQ-028 Burst: FIFO preloaded 0x01..0x04, almost_empty=0, enable=1, out_ready=1 -> out_data 0x01,0x02,0x03,0x04 on 4 consecutive cycles; word_count=4.
REQ-029 Backpressure: out_ready=0 for 5 cycles -> at most 2 pops (buffer full), out_data=0x01 held stable; on release, words follow in order with none lost or duplicated.
REQ-030 Paced: almost_empty=1 with 3 words -> fifo_rd high every other cycle, state alternates 2/3, 3 words delivered, no pop while fifo_empty=1.
REQ-031 Enable drop: enable falls in the cycle after a pop -> that word is still delivered; no further fifo_rd; state=IDLE.
REQ-032 Reset mid-burst: reset=0 for 1 cycle with 2 words buffered -> out_valid=0, word_count=0 next cycle; the stale FIFO return is not output.
REQ-033 Wrap: 256 transfers with CNT_WIDTH=8 -> word_count=0.
